// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches an opcode word and, for jump opcodes 0x14..0x24, its target word, then presents both to the branch logic.
// Optional: define FETCH_STALL_COUNT_EN to add the stall_count output (saturating count of memory wait cycles).
module instruction_fetch_unit #(
    parameter int WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] peek_jump_address,
    output logic [WORD_SIZE-1:0] program_counter_address,
    input  logic [WORD_SIZE-1:0] new_address
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [WORD_SIZE-1:0] stall_count
`endif
);
    typedef enum logic [2:0] {FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, PRESENT} state_t;
    state_t state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d, instruction_q, instruction_d;
    logic [WORD_SIZE-1:0] peek_q, peek_d, pca_q, pca_d, pc_arg;
    logic mem_req_q, mem_req_d, instr_valid_q, instr_valid_d, is_jump;
    assign pc_arg = pc_q + WORD_SIZE'(2);
    assign is_jump = mem_rdata[15:8] >= 8'h14 && mem_rdata[15:8] <= 8'h24;
    assign mem_req = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instruction = instruction_q;
    assign peek_jump_address = peek_q;
    assign program_counter_address = pca_q;
    // Next-state logic: issue reads, capture acked words, hand the bundle over on ready.
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        mem_req_d = mem_req_q;
        mem_addr_d = mem_addr_q;
        instr_valid_d = instr_valid_q;
        instruction_d = instruction_q;
        peek_d = peek_q;
        pca_d = pca_q;
        case (state_q)
            FETCH_OP: begin
                mem_req_d = 1'b1;
                mem_addr_d = pc_q;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (mem_ack) begin
                mem_req_d = 1'b0;
                instruction_d = mem_rdata;
                peek_d = '0;
                pca_d = pc_q;
                instr_valid_d = !is_jump;
                state_d = is_jump ? FETCH_ARG : PRESENT;
            end
            FETCH_ARG: begin
                mem_req_d = 1'b1;
                mem_addr_d = pc_arg;
                state_d = WAIT_ARG;
            end
            WAIT_ARG: if (mem_ack) begin
                mem_req_d = 1'b0;
                peek_d = mem_rdata;
                pca_d = pc_arg;
                instr_valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: if (instr_ready) begin
                pc_d = new_address;
                instr_valid_d = 1'b0;
                state_d = FETCH_OP;
            end
            default: state_d = FETCH_OP;
        endcase
    end
    // State and output registers; reset abandons any outstanding read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_OP;
            pc_q <= RESET_VECTOR;
            mem_req_q <= 1'b0;
            mem_addr_q <= RESET_VECTOR;
            instr_valid_q <= 1'b0;
            instruction_q <= '0;
            peek_q <= '0;
            pca_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            mem_req_q <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            instruction_q <= instruction_d;
            peek_q <= peek_d;
            pca_q <= pca_d;
        end
    end
`ifdef FETCH_STALL_COUNT_EN
    logic [WORD_SIZE-1:0] stall_q, stall_d;
    assign stall_count = stall_q;
    // Count un-acked wait cycles, holding at all-ones.
    always_comb stall_d = ((state_q == WAIT_OP || state_q == WAIT_ARG) && !mem_ack && !(&stall_q)) ? stall_q + WORD_SIZE'(1) : stall_q;
    // Stall counter register.
    always_ff @(posedge clk) stall_q <= reset ? '0 : stall_d;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized bench for instruction_fetch_unit against a bundle-level reference model.
module tb_instruction_fetch_unit;
    logic clk = 1'b0, reset = 1'b1, mem_req, mem_ack, instr_valid, instr_ready = 1'b0;
    logic [15:0] mem_addr, mem_rdata, instruction, peek_jump_address, program_counter_address;
    logic [15:0] new_address = 16'h0;
`ifdef FETCH_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif
    logic r_ack = 1'b0, m_ack = 1'b0, resp_en = 1'b1, busy = 1'b0;
    logic [15:0] r_data = 16'h0, m_data = 16'h0, a0 = 16'h0;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] reads [$];
    int fixed_dly = 0, dly = 0, cnt = 0, unstable = 0, stall_model = 0;
    int checks = 0, errors = 0;
    assign mem_ack = resp_en ? r_ack : m_ack;
    assign mem_rdata = resp_en ? r_data : m_data;

    instruction_fetch_unit #(.WORD_SIZE(16), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .peek_jump_address(peek_jump_address),
        .program_counter_address(program_counter_address), .new_address(new_address)
`ifdef FETCH_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents, filled lazily with roughly half jump opcodes.
    function automatic logic [15:0] rd(input logic [15:0] a);
        if (!mem.exists(a))
            mem[a] = $urandom_range(0, 1) ? {8'($urandom_range(8'h14, 8'h24)), 8'($urandom)} : 16'($urandom);
        return mem[a];
    endfunction

    // Reference model: what one bundle fetched at pc must look like.
    function automatic void model(input logic [15:0] pc, output logic [15:0] ins, output logic [15:0] pk,
                                  output logic [15:0] pca, output logic [15:0] arg, output logic jmp);
        ins = rd(pc);
        jmp = ins[15:8] >= 8'h14 && ins[15:8] <= 8'h24;
        arg = pc + 16'd2;
        pk = jmp ? rd(arg) : 16'h0;
        pca = jmp ? arg : pc;
    endfunction

    // Memory responder: acks each request after a fixed or random number of wait cycles.
    always @(negedge clk) begin
        r_ack = 1'b0;
        if (!mem_req) busy = 1'b0;
        else if (resp_en) begin
            if (!busy) begin
                busy = 1'b1;
                cnt = 0;
                a0 = mem_addr;
                dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 3));
                reads.push_back(mem_addr);
            end else if (mem_addr !== a0) unstable++;
            if (cnt == dly) begin
                r_ack = 1'b1;
                r_data = rd(mem_addr);
                busy = 1'b0;
                stall_model += dly;
            end else cnt++;
        end
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (instr_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake(input logic [15:0] a);
        new_address = a;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        new_address = 16'hDEAD;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        reads.delete();
        stall_model = 0;
        unstable = 0;
    endtask

    task automatic test_reset();
        int n;
        mem[16'h0000] = 16'h0500;
        fixed_dly = 0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 16'h0 || peek_jump_address !== 16'h0 ||
            program_counter_address !== 16'h0 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_values: req=%b valid=%b instr=%h peek=%h pca=%h addr=%h, want 0 0 0000 0000 0000 0000",
                     mem_req, instr_valid, instruction, peek_jump_address, program_counter_address, mem_addr);
        end
        reset = 1'b0;
        reads.delete();
        stall_model = 0;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_first_cycle_req: got %b want 0", mem_req); end
        wait_valid(n);
        checks++;
        if (n != 2) begin errors++; $display("FAIL reset_latency: got %0d want 2", n); end
        checks++;
        if (instruction !== 16'h0500 || peek_jump_address !== 16'h0 || program_counter_address !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bundle: instr=%h peek=%h pca=%h want 0500 0000 0000", instruction, peek_jump_address, program_counter_address);
        end
    endtask

    task automatic test_jump();
        int n;
        mem[16'h0010] = 16'h1400;
        mem[16'h0012] = 16'h0040;
        mem[16'h0040] = 16'h0100;
        reads.delete();
        handshake(16'h0010);
        wait_valid(n);
        checks++;
        if (n != 4) begin errors++; $display("FAIL jump_latency: got %0d want 4", n); end
        checks++;
        if (reads.size() != 2 || reads[0] !== 16'h0010 || reads[1] !== 16'h0012) begin
            errors++;
            $display("FAIL jump_reads: got %0d reads (%p) want 0010,0012", reads.size(), reads);
        end
        checks++;
        if (instruction !== 16'h1400 || peek_jump_address !== 16'h0040 || program_counter_address !== 16'h0012) begin
            errors++;
            $display("FAIL jump_bundle: instr=%h peek=%h pca=%h want 1400 0040 0012", instruction, peek_jump_address, program_counter_address);
        end
        reads.delete();
        handshake(16'h0040);
        wait_valid(n);
        checks++;
        if (reads.size() != 1 || reads[0] !== 16'h0040 || instruction !== 16'h0100) begin
            errors++;
            $display("FAIL jump_follow: reads=%p instr=%h want 0040 / 0100", reads, instruction);
        end
    endtask

    task automatic test_delay();
        int n = 0, hi = 0, bad = 0;
        mem[16'h0000] = 16'h0500;
        fixed_dly = 4;
        do_reset();
        while (instr_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
            if (mem_req === 1'b1) begin
                hi++;
                if (mem_addr !== 16'h0000) bad++;
            end
        end
        fixed_dly = -1;
        checks++;
        if (n != 6 || hi != 5 || bad != 0 || unstable != 0) begin
            errors++;
            $display("FAIL delay_hold: latency=%0d req_cycles=%0d bad_addr=%0d unstable=%0d want 6 5 0 0", n, hi, bad, unstable);
        end
`ifdef FETCH_STALL_COUNT_EN
        checks++;
        if (stall_count !== 16'd4) begin errors++; $display("FAIL delay_stall_count: got %0d want 4", stall_count); end
`endif
    endtask

    task automatic test_hold();
        int n;
        logic [15:0] na = 16'h0100 + 16'($urandom_range(0, 255) * 2);
        logic [15:0] ins, pk, pca, arg;
        logic jmp;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instruction !== 16'h0500 || peek_jump_address !== 16'h0 ||
                program_counter_address !== 16'h0000) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b req=%b instr=%h peek=%h pca=%h want 1 0 0500 0000 0000",
                         i, instr_valid, mem_req, instruction, peek_jump_address, program_counter_address);
            end
            @(negedge clk);
        end
        model(na, ins, pk, pca, arg, jmp);
        reads.delete();
        handshake(na);
        wait_valid(n);
        checks++;
        if (reads.size() == 0 || reads[0] !== na || instruction !== ins || program_counter_address !== pca) begin
            errors++;
            $display("FAIL hold_release: reads=%p instr=%h pca=%h want first %h instr %h pca %h", reads, instruction, program_counter_address, na, ins, pca);
        end
    endtask

    task automatic test_wrap();
        int n;
        mem[16'hFFFE] = 16'h2400;
        mem[16'h0000] = 16'h0500;
        reads.delete();
        handshake(16'hFFFE);
        wait_valid(n);
        checks++;
        if (reads.size() != 2 || reads[0] !== 16'hFFFE || reads[1] !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_reads: got %p want FFFE,0000", reads);
        end
        checks++;
        if (instruction !== 16'h2400 || peek_jump_address !== 16'h0500 || program_counter_address !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_bundle: instr=%h peek=%h pca=%h want 2400 0500 0000", instruction, peek_jump_address, program_counter_address);
        end
    endtask

    task automatic test_ready_ignored();
        int n = 0;
        mem[16'h0300] = 16'h0700;
        mem[16'h0500] = 16'h0600;
        reads.delete();
        new_address = 16'h0300;
        instr_ready = 1'b1;
        @(negedge clk);
        new_address = 16'h0500;
        while (instr_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (reads.size() < 1 || reads[0] !== 16'h0300 || instruction !== 16'h0700 || program_counter_address !== 16'h0300) begin
            errors++;
            $display("FAIL ready_early: reads=%p instr=%h pca=%h want 0300 / 0700 / 0300", reads, instruction, program_counter_address);
        end
        @(negedge clk);
        instr_ready = 1'b0;
        wait_valid(n);
        checks++;
        if (reads.size() != 2 || reads[1] !== 16'h0500 || instruction !== 16'h0600) begin
            errors++;
            $display("FAIL ready_next: reads=%p instr=%h want 0300,0500 / 0600", reads, instruction);
        end
    endtask

    task automatic test_random();
        int n;
        logic [15:0] pc, ins, pk, pca, arg;
        logic jmp;
        fixed_dly = -1;
        for (int i = 0; i < 40; i++) begin
            pc = 16'($urandom) & 16'hFFFE;
            model(pc, ins, pk, pca, arg, jmp);
            reads.delete();
            handshake(pc);
            wait_valid(n);
            checks++;
            if (n >= 64) begin
                errors++;
                $display("FAIL rand%0d_timeout: no instr_valid within %0d cycles", i, n);
            end else if (instruction !== ins || peek_jump_address !== pk || program_counter_address !== pca ||
                         reads.size() != (jmp ? 2 : 1) || reads[0] !== pc || (jmp && reads[reads.size()-1] !== arg)) begin
                errors++;
                $display("FAIL rand%0d_bundle: pc=%h instr=%h peek=%h pca=%h reads=%p want %h %h %h jump=%b",
                         i, pc, instruction, peek_jump_address, program_counter_address, reads, ins, pk, pca, jmp);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL rand_addr_stable: %0d address changes while waiting, want 0", unstable); end
`ifdef FETCH_STALL_COUNT_EN
        checks++;
        if (stall_count !== 16'(stall_model)) begin errors++; $display("FAIL rand_stall_count: got %0d want %0d", stall_count, stall_model); end
`endif
    endtask

    task automatic test_stale_ack();
        resp_en = 1'b0;
        m_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL stale_op_req: req=%b addr=%h want 1 0000", mem_req, mem_addr); end
        m_ack = 1'b1;
        m_data = 16'h1800;
        @(negedge clk);
        m_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL stale_arg_req: req=%b addr=%h want 1 0002", mem_req, mem_addr); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_ack = 1'b1;
        m_data = 16'h5555;
        @(negedge clk);
        m_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0 || instruction !== 16'h0 || peek_jump_address !== 16'h0) begin
            errors++;
            $display("FAIL stale_ignored: req=%b addr=%h valid=%b instr=%h peek=%h want 1 0000 0 0000 0000",
                     mem_req, mem_addr, instr_valid, instruction, peek_jump_address);
        end
        m_ack = 1'b1;
        m_data = 16'h0900;
        @(negedge clk);
        m_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instruction !== 16'h0900 || peek_jump_address !== 16'h0 || program_counter_address !== 16'h0000) begin
            errors++;
            $display("FAIL stale_fresh: valid=%b instr=%h peek=%h pca=%h want 1 0900 0000 0000",
                     instr_valid, instruction, peek_jump_address, program_counter_address);
        end
        resp_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_jump();
        test_delay();
        test_hold();
        test_wrap();
        test_ready_ignored();
        test_random();
        test_stale_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL provide parameter WORD_SIZE, default 16: width of address, instruction and data words.
REQ-002 SHALL provide parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1: memory read request.
REQ-006 SHALL have port mem_addr  output  WORD_SIZE: read address, valid while mem_req=1.
REQ-007 SHALL have port mem_ack  input  1: one-cycle pulse marking mem_rdata valid.
REQ-008 SHALL have port mem_rdata  input  WORD_SIZE: read data.
REQ-009 SHALL have port instr_valid  output  1: instruction bundle presented to the branch decision logic.
REQ-010 SHALL have port instr_ready  input  1: consumer accepts the bundle.
REQ-011 SHALL have port instruction  output  WORD_SIZE: fetched opcode word; opcode in [15:8].
REQ-012 SHALL have port peek_jump_address  output  WORD_SIZE: jump target word.
REQ-013 SHALL have port program_counter_address  output  WORD_SIZE: address of the last word consumed for this bundle.
REQ-014 SHALL have port new_address  input  WORD_SIZE: next fetch address returned by the branch decision logic.

Function
REQ-015 SHALL implement FSM states FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, PRESENT.
REQ-016 FETCH_OP SHALL assert mem_req with mem_addr=pc and go to WAIT_OP in the same cycle.
REQ-017 mem_req and mem_addr SHALL stay stable from WAIT_OP entry until mem_ack; on mem_ack, mem_req SHALL deassert in the next cycle.
REQ-018 In WAIT_OP on mem_ack, mem_rdata SHALL be latched into instruction.
REQ-019 If mem_rdata[15:8] is in 0x14..0x24 inclusive (jump opcode), the FSM SHALL go to FETCH_ARG; otherwise it SHALL go to PRESENT with peek_jump_address=0 and program_counter_address=pc.
REQ-020 FETCH_ARG/WAIT_ARG SHALL read address pc+2, latch mem_rdata into peek_jump_address, set program_counter_address=pc+2, and then go to PRESENT.
REQ-021 PRESENT SHALL hold instr_valid=1 with instruction, peek_jump_address and program_counter_address stable until instr_ready=1.
REQ-022 On the cycle with instr_valid and instr_ready both 1, pc SHALL load new_address, instr_valid SHALL drop next cycle, and the FSM SHALL go to FETCH_OP.
REQ-023 Minimum latency, with ack in the cycle after the request: non-jump 3 cycles and jump 5 cycles from FETCH_OP to instr_valid.
REQ-024 Address arithmetic SHALL be modulo 2^WORD_SIZE: pc=0xFFFE gives operand address 0x0000.
REQ-025 mem_ack outside WAIT_OP/WAIT_ARG SHALL be ignored.
REQ-026 instr_ready while instr_valid=0 SHALL be ignored.

Reset
REQ-027 On reset, pc SHALL become RESET_VECTOR and the state SHALL become FETCH_OP.
REQ-028 On reset, mem_req, instr_valid, instruction, peek_jump_address and program_counter_address SHALL be 0 and mem_addr SHALL be RESET_VECTOR.
REQ-029 Reset during WAIT_OP/WAIT_ARG SHALL abandon the outstanding read; a stale ack in the cycle after reset SHALL be ignored.
REQ-030 The first request after reset release SHALL issue no earlier than the second cycle after reset deasserts.

Configuration
REQ-031 With macro FETCH_STALL_COUNT_EN defined, the block SHALL add output stall_count  WORD_SIZE.
REQ-032 stall_count SHALL count cycles spent in WAIT_OP/WAIT_ARG without mem_ack, saturate at all-ones, and clear on reset.
REQ-033 Without FETCH_STALL_COUNT_EN, the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-034 Reset, then mem[0x0000]=0x0500 with immediate ack -> instr_valid at cycle 3, instruction=0x0500, peek=0, program_counter_address=0x0000.
REQ-035 mem[0x0010]=0x1400, mem[0x0012]=0x0040 -> two reads (0x0010, 0x0012), peek=0x0040, program_counter_address=0x0012; new_address=0x0040 then next mem_addr=0x0040.
REQ-036 Ack delayed 4 cycles -> mem_addr held constant for 5 cycles; stall_count=4 when FETCH_STALL_COUNT_EN is defined.
REQ-037 instr_ready held low 10 cycles in PRESENT -> outputs stable throughout with no mem_req; pc loads on the cycle instr_ready rises.
REQ-038 pc=0xFFFE with opcode 0x2400 -> operand read at 0x0000.
REQ-039 Reset asserted in WAIT_ARG with ack the next cycle -> ack ignored and a fresh read issued at RESET_VECTOR.
